// File: rtl/lenet_pkg.sv
// Shared constants, types and address helpers for the LeNet conv1 sequencer.
package lenet_pkg;

  localparam int BITWIDTH  = 16;
  localparam int FRAC      = 8;
  localparam int IMG_DIM   = 32;
  localparam int K_DIM     = 5;
  localparam int FM_DIM    = 28;
  localparam int N_KERNELS = 2;

  localparam int IMG_AW = $clog2(IMG_DIM * IMG_DIM);
  localparam int KER_AW = $clog2(N_KERNELS * K_DIM * K_DIM);
  localparam int FM_AW  = $clog2(N_KERNELS * FM_DIM * FM_DIM);
  localparam int POS_W  = $clog2(FM_DIM);
  localparam int TAP_W  = $clog2(K_DIM);
  localparam int KIDX_W = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int ACC_W  = 2 * BITWIDTH + 5;

  typedef logic signed [BITWIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } conv_state_t;

  function automatic logic [IMG_AW-1:0] img_address(input logic [POS_W-1:0] i,
                                                    input logic [POS_W-1:0] j,
                                                    input logic [TAP_W-1:0] l,
                                                    input logic [TAP_W-1:0] m);
    logic [IMG_AW-1:0] row;
    logic [IMG_AW-1:0] col;
    row = IMG_AW'(i) + IMG_AW'(l);
    col = IMG_AW'(j) + IMG_AW'(m);
    return row * IMG_AW'(IMG_DIM) + col;
  endfunction

  function automatic logic [KER_AW-1:0] ker_address(input logic [KIDX_W-1:0] k,
                                                    input logic [TAP_W-1:0] l,
                                                    input logic [TAP_W-1:0] m);
    return KER_AW'(k) * KER_AW'(K_DIM * K_DIM) + KER_AW'(l) * KER_AW'(K_DIM) + KER_AW'(m);
  endfunction

endpackage

// File: rtl/conv1_scheduler_if.sv
// Image/kernel RAM read ports and feature-map write port of the conv1 sequencer.
interface conv1_scheduler_if;
  import lenet_pkg::*;

  logic              img_rd_en;
  logic [IMG_AW-1:0] img_addr;
  data_t             img_rdata;
  logic              ker_rd_en;
  logic [KER_AW-1:0] ker_addr;
  data_t             ker_rdata;
  logic              fm_valid;
  logic              fm_ready;
  logic [FM_AW-1:0]  fm_addr;
  data_t             fm_data;

  modport master (
    output img_rd_en, img_addr, ker_rd_en, ker_addr, fm_valid, fm_addr, fm_data,
    input  img_rdata, ker_rdata, fm_ready
  );

  modport slave (
    input  img_rd_en, img_addr, ker_rd_en, ker_addr, fm_valid, fm_addr, fm_data,
    output img_rdata, ker_rdata, fm_ready
  );

endinterface

// File: rtl/conv1_mac_unit.sv
// Multiply-accumulate datapath: rescale, saturate and (with CONV1_RELU_EN) ReLU
// into a registered result.
module conv1_mac_unit import lenet_pkg::*; (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  acc_en,
  input  logic  load,
  input  data_t a,
  input  data_t b,
  output data_t result
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (BITWIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [2*BITWIDTH-1:0] a_ext_s;
  logic signed [2*BITWIDTH-1:0] b_ext_s;
  logic signed [2*BITWIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]      prod_ext_s;
  logic signed [ACC_W-1:0]      sum_s;
  logic signed [ACC_W-1:0]      shifted_s;
  logic signed [ACC_W-1:0]      acc_r;
  data_t                        sat_s;
  data_t                        out_s;
  data_t                        result_r;

  // Sum includes the in-flight product so the DRAIN cycle can load the final value directly.
  always_comb begin
    a_ext_s    = {{BITWIDTH{a[BITWIDTH-1]}}, a};
    b_ext_s    = {{BITWIDTH{b[BITWIDTH-1]}}, b};
    prod_s     = a_ext_s * b_ext_s;
    prod_ext_s = {{(ACC_W-2*BITWIDTH){prod_s[2*BITWIDTH-1]}}, prod_s};
    sum_s      = acc_r + (acc_en ? prod_ext_s : ACC_W'(0));
    shifted_s  = sum_s >>> FRAC;
    if (shifted_s > SAT_MAX) begin
      sat_s = {1'b0, {(BITWIDTH-1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      sat_s = {1'b1, {(BITWIDTH-1){1'b0}}};
    end else begin
      sat_s = shifted_s[BITWIDTH-1:0];
    end
`ifdef CONV1_RELU_EN
    out_s = sat_s[BITWIDTH-1] ? data_t'(0) : sat_s;
`else
    out_s = sat_s;
`endif
  end

  // Accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= ACC_W'(0);
      result_r <= data_t'(0);
    end else begin
      if (clear) begin
        acc_r <= ACC_W'(0);
      end else if (acc_en) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (load) begin
        result_r <= out_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign result = result_r;

endmodule

// File: rtl/conv1_scheduler.sv
// Conv1 sequencer: walks k/i/j output positions and 25 kernel taps through one MAC.
// Optional ReLU on results is enabled with CONV1_RELU_EN.
module conv1_scheduler import lenet_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  conv1_scheduler_if.master bus
);

  conv_state_t       state_r;
  logic              busy_r;
  logic              done_r;
  logic              img_rd_en_r;
  logic              ker_rd_en_r;
  logic              fm_valid_r;
  logic [IMG_AW-1:0] img_addr_r;
  logic [KER_AW-1:0] ker_addr_r;
  logic [FM_AW-1:0]  fm_addr_r;
  logic [KIDX_W-1:0] k_r;
  logic [POS_W-1:0]  i_r;
  logic [POS_W-1:0]  j_r;
  logic [TAP_W-1:0]  l_r;
  logic [TAP_W-1:0]  m_r;

  logic [KIDX_W-1:0] k_nxt_s;
  logic [POS_W-1:0]  i_nxt_s;
  logic [POS_W-1:0]  j_nxt_s;
  logic [TAP_W-1:0]  l_nxt_s;
  logic [TAP_W-1:0]  m_nxt_s;
  logic              last_tap_s;
  logic              last_out_s;
  logic              mac_clear_s;
  logic              mac_acc_en_s;
  logic              mac_load_s;
  data_t             fm_data_s;

  // Data seen in a MAC cycle belongs to the previous tap, so tap 0's cycle adds nothing.
  always_comb begin
    last_tap_s   = (l_r == TAP_W'(K_DIM - 1)) && (m_r == TAP_W'(K_DIM - 1));
    last_out_s   = (k_r == KIDX_W'(N_KERNELS - 1)) && (i_r == POS_W'(FM_DIM - 1)) &&
                   (j_r == POS_W'(FM_DIM - 1));
    mac_clear_s  = ((state_r == IDLE) && start) || ((state_r == WRITE) && bus.fm_ready);
    mac_acc_en_s = ((state_r == MAC) && !((l_r == TAP_W'(0)) && (m_r == TAP_W'(0)))) ||
                   (state_r == DRAIN);
    mac_load_s   = (state_r == DRAIN);
    if (m_r == TAP_W'(K_DIM - 1)) begin
      m_nxt_s = TAP_W'(0);
      l_nxt_s = l_r + TAP_W'(1);
    end else begin
      m_nxt_s = m_r + TAP_W'(1);
      l_nxt_s = l_r;
    end
    k_nxt_s = k_r;
    i_nxt_s = i_r;
    if (j_r == POS_W'(FM_DIM - 1)) begin
      j_nxt_s = POS_W'(0);
      if (i_r == POS_W'(FM_DIM - 1)) begin
        i_nxt_s = POS_W'(0);
        k_nxt_s = k_r + KIDX_W'(1);
      end else begin
        i_nxt_s = i_r + POS_W'(1);
      end
    end else begin
      j_nxt_s = j_r + POS_W'(1);
    end
  end

  // Sequencer FSM with registered strobes and addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      img_rd_en_r <= 1'b0;
      ker_rd_en_r <= 1'b0;
      fm_valid_r  <= 1'b0;
      img_addr_r  <= IMG_AW'(0);
      ker_addr_r  <= KER_AW'(0);
      fm_addr_r   <= FM_AW'(0);
      k_r         <= KIDX_W'(0);
      i_r         <= POS_W'(0);
      j_r         <= POS_W'(0);
      l_r         <= TAP_W'(0);
      m_r         <= TAP_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= MAC;
            busy_r      <= 1'b1;
            k_r         <= KIDX_W'(0);
            i_r         <= POS_W'(0);
            j_r         <= POS_W'(0);
            l_r         <= TAP_W'(0);
            m_r         <= TAP_W'(0);
            fm_addr_r   <= FM_AW'(0);
            img_rd_en_r <= 1'b1;
            ker_rd_en_r <= 1'b1;
            img_addr_r  <= img_address(POS_W'(0), POS_W'(0), TAP_W'(0), TAP_W'(0));
            ker_addr_r  <= ker_address(KIDX_W'(0), TAP_W'(0), TAP_W'(0));
          end
        end
        MAC: begin
          if (last_tap_s) begin
            state_r     <= DRAIN;
            img_rd_en_r <= 1'b0;
            ker_rd_en_r <= 1'b0;
          end else begin
            l_r        <= l_nxt_s;
            m_r        <= m_nxt_s;
            img_addr_r <= img_address(i_r, j_r, l_nxt_s, m_nxt_s);
            ker_addr_r <= ker_address(k_r, l_nxt_s, m_nxt_s);
          end
        end
        DRAIN: begin
          state_r    <= WRITE;
          fm_valid_r <= 1'b1;
        end
        WRITE: begin
          if (bus.fm_ready) begin
            fm_valid_r <= 1'b0;
            if (last_out_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r     <= MAC;
              k_r         <= k_nxt_s;
              i_r         <= i_nxt_s;
              j_r         <= j_nxt_s;
              l_r         <= TAP_W'(0);
              m_r         <= TAP_W'(0);
              fm_addr_r   <= fm_addr_r + FM_AW'(1);
              img_rd_en_r <= 1'b1;
              ker_rd_en_r <= 1'b1;
              img_addr_r  <= img_address(i_nxt_s, j_nxt_s, TAP_W'(0), TAP_W'(0));
              ker_addr_r  <= ker_address(k_nxt_s, TAP_W'(0), TAP_W'(0));
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          img_rd_en_r <= 1'b0;
          ker_rd_en_r <= 1'b0;
          fm_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  conv1_mac_unit u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear_s),
    .acc_en (mac_acc_en_s),
    .load   (mac_load_s),
    .a      (bus.img_rdata),
    .b      (bus.ker_rdata),
    .result (fm_data_s)
  );

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.img_rd_en = img_rd_en_r;
  assign bus.img_addr  = img_addr_r;
  assign bus.ker_rd_en = ker_rd_en_r;
  assign bus.ker_addr  = ker_addr_r;
  assign bus.fm_valid  = fm_valid_r;
  assign bus.fm_addr   = fm_addr_r;
  assign bus.fm_data   = fm_data_s;

endmodule

// File: tb/tb_conv1_scheduler.sv
// Directed bench for conv1_scheduler: full layer with stall, single-pixel ordering with
// mid-run reset, and saturation on a fresh start. Define CONV1_RELU_EN for the ReLU build.
module tb_conv1_scheduler;
  import lenet_pkg::*;

`ifdef CONV1_RELU_EN
  localparam int RELU = 1;
`else
  localparam int RELU = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  conv1_scheduler_if bus();

  conv1_scheduler dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  data_t img_mem [IMG_DIM*IMG_DIM];
  data_t ker_mem [N_KERNELS*K_DIM*K_DIM];

  // One-cycle-latency RAM models.
  always @(posedge clk) begin
    if (bus.img_rd_en) bus.img_rdata <= img_mem[bus.img_addr];
    if (bus.ker_rd_en) bus.ker_rdata <= ker_mem[bus.ker_addr];
  end

  typedef struct {
    int addr;
    int data;
    int rel;
  } wr_t;

  wr_t wq[$];
  int n_vec = 0;
  int n_miss = 0;
  int sample_cnt = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int done_busy = 0;
  int stall_viol = 0;
  int rd_in_write = 0;
  logic prev_stall = 1'b0;
  int prev_addr = 0;
  int prev_data = 0;

  // Monitor samples mid-cycle, after the testbench has driven its inputs.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      sample_cnt = sample_cnt + 1;
      if (prev_stall && !(bus.fm_valid && int'(bus.fm_addr) == prev_addr &&
                          int'(bus.fm_data) == prev_data)) stall_viol = stall_viol + 1;
      if (bus.fm_valid && (bus.img_rd_en || bus.ker_rd_en)) rd_in_write = rd_in_write + 1;
      prev_stall = bus.fm_valid && !bus.fm_ready;
      prev_addr  = int'(bus.fm_addr);
      prev_data  = int'(bus.fm_data);
      if (bus.fm_valid && bus.fm_ready)
        wq.push_back('{int'(bus.fm_addr), int'(bus.fm_data), sample_cnt - t0});
      if (done) begin
        done_cnt  = done_cnt + 1;
        done_rel  = sample_cnt - t0;
        done_busy = int'(busy);
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int img_v, input int k0_v, input int k1_v);
    for (int a = 0; a < IMG_DIM*IMG_DIM; a++) img_mem[a] = data_t'(img_v);
    for (int a = 0; a < K_DIM*K_DIM; a++) begin
      ker_mem[a]               = data_t'(k0_v);
      ker_mem[a + K_DIM*K_DIM] = data_t'(k1_v);
    end
  endtask

  task automatic start_layer();
    @(negedge clk);
    start       = 1'b1;
    t0          = sample_cnt + 1;
    wq.delete();
    done_cnt    = 0;
    done_rel    = -1;
    stall_viol  = 0;
    rd_in_write = 0;
    prev_stall  = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_done"}, done, 0);
    check_val({pfx, "_img_rd_en"}, bus.img_rd_en, 0);
    check_val({pfx, "_ker_rd_en"}, bus.ker_rd_en, 0);
    check_val({pfx, "_img_addr"}, bus.img_addr, 0);
    check_val({pfx, "_ker_addr"}, bus.ker_addr, 0);
    check_val({pfx, "_fm_valid"}, bus.fm_valid, 0);
    check_val({pfx, "_fm_addr"}, bus.fm_addr, 0);
    check_val({pfx, "_fm_data"}, bus.fm_data, 0);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (wq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (wq.size() < n) check_val(tag, wq.size(), n);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == 0) check_val(tag, done_cnt, 1);
  endtask

  initial begin
    int c;
    int addr_err;
    int data_err;
    int time_err;
    int activity;
    int exp_d;

    rst          = 1'b1;
    start        = 1'b0;
    bus.fm_ready = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Run A: 1.0 image, +/-1.0 kernels, 10-cycle stall at the first write, stray start.
    fill(256, 256, -256);
    start_layer();
    c = 0;
    while (!bus.fm_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_val("A_first_valid_cycle", sample_cnt + 1 - t0, 27);
    repeat (9) @(negedge clk);
    check_val("A_stall_valid", bus.fm_valid, 1);
    check_val("A_stall_addr", bus.fm_addr, 0);
    check_val("A_stall_data", bus.fm_data, 6400);
    check_val("A_stall_img_rd", bus.img_rd_en, 0);
    check_val("A_stall_ker_rd", bus.ker_rd_en, 0);
    @(negedge clk);
    bus.fm_ready = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(45000, "A_done_timeout");
    check_val("A_done_cycle", done_rel, 42347);
    check_val("A_done_busy", done_busy, 0);
    check_val("A_writes", wq.size(), 1568);
    check_val("A_stall_stable", stall_viol, 0);
    check_val("A_rd_during_write", rd_in_write, 0);
    addr_err = 0;
    data_err = 0;
    time_err = 0;
    foreach (wq[n]) begin
      exp_d = (n < 784) ? 6400 : ((RELU != 0) ? 0 : -6400);
      if (wq[n].addr != n) addr_err++;
      if (wq[n].data != exp_d) data_err++;
      if (wq[n].rel != 27 * (n + 1) + 10) time_err++;
    end
    check_val("A_addr_order", addr_err, 0);
    check_val("A_data", data_err, 0);
    check_val("A_timing", time_err, 0);
    if (wq.size() == 1568) check_val("A_last_data", wq[1567].data, (RELU != 0) ? 0 : -6400);
    repeat (3) @(negedge clk);
    check_val("A_done_pulse_width", done_cnt, 1);
    check_val("A_idle_busy", busy, 0);

    // Run B: single pixel for ordering, reset (with start) at the 100th handshake.
    fill(0, 0, 0);
    img_mem[2*IMG_DIM + 3] = data_t'(256);
    ker_mem[2*K_DIM + 2]   = data_t'(256);
    start_layer();
    c = 0;
    while (!(wq.size() == 99 && bus.fm_valid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check_val("B_reach_100th", wq.size(), 99);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_outputs_zero("B_after_rst");
    rst   = 1'b0;
    start = 1'b0;
    activity = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || bus.img_rd_en || bus.ker_rd_en || bus.fm_valid) activity++;
    end
    check_val("B_quiet_after_rst", activity, 0);
    check_val("B_writes", wq.size(), 100);
    addr_err = 0;
    data_err = 0;
    foreach (wq[n]) begin
      if (wq[n].addr != n) addr_err++;
      if (wq[n].data != ((n == 1) ? 256 : 0)) data_err++;
    end
    check_val("B_addr_order", addr_err, 0);
    check_val("B_data", data_err, 0);
    if (wq.size() > 1) check_val("B_pixel_out", wq[1].data, 256);

    // Run C: fresh start with saturating operands, stopped after kernel 1 begins.
    fill(32767, 32767, -32768);
    start_layer();
    wait_writes(790, 22000, "C_write_timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    addr_err = 0;
    data_err = 0;
    time_err = 0;
    foreach (wq[n]) begin
      exp_d = (n < 784) ? 32767 : ((RELU != 0) ? 0 : -32768);
      if (wq[n].addr != n) addr_err++;
      if (wq[n].data != exp_d) data_err++;
      if (wq[n].rel != 27 * (n + 1)) time_err++;
    end
    check_val("C_addr_order", addr_err, 0);
    check_val("C_data_sat", data_err, 0);
    check_val("C_timing", time_err, 0);
    if (wq.size() > 784) begin
      check_val("C_first_addr", wq[0].addr, 0);
      check_val("C_first_cycle", wq[0].rel, 27);
      check_val("C_k1_first", wq[784].data, (RELU != 0) ? 0 : -32768);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
